// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction fetch handshake and next-PC selection
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] issue_count
);

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    ISSUE      = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        capture;
  logic        issue;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign imem_addr  = pc;
  assign opcode     = instr[31:26];
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    issue       = 1'b0;
    case (state)
      RESET_WAIT: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          issue      = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = RESET_WAIT;
    endcase
  end

  // jump outranks a taken branch
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RESET_WAIT;
      pc          <= {RESET_PC[31:2], 2'b00};
      instr       <= 32'd0;
      issue_count <= 32'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        instr <= imem_rdata;
      end
      if (issue) begin
        pc          <= next_pc;
        issue_count <= issue_count + 32'd1;
      end
    end
  end

endmodule
